// File: rtl/int_controller_pkg.sv
// Shared types and helpers for the N-channel interrupt controller:
// FSM encoding, priority-mode constants, vector and rotated-rank arithmetic.
package int_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      VECTOR = 2'd2
   } state_t;

   localparam int PRIO_FIXED  = 0;
   localparam int PRIO_ROTATE = 1;

   // Vector address wraps modulo 2^32.
   function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [31:0] idx);
      return base + idx * stride;
   endfunction

   // Position of channel ch in the search order that starts at start (0 = highest).
   function automatic int rot_rank(input int ch, input int start, input int n);
      int r;
      r = ch - start;
      if (r < 0) r = r + n;
      return r;
   endfunction

endpackage

// File: rtl/int_controller_if.sv
// Request/acknowledge/vector bundle between peripherals, control unit and the
// interrupt controller; slave is the controller side.
interface int_controller_if #(parameter int N_CHAN = 8);

   logic [N_CHAN-1:0] IRQ;
   logic              MASK_WE;
   logic [N_CHAN-1:0] MASK_IN;
   logic              INTA_IN;
   logic              DATA_RD;
   logic              EOI;
   logic              INTA_OUT;
   logic              INT;
   logic [31:0]       DATA;
   logic [N_CHAN-1:0] PENDING;
   logic [N_CHAN-1:0] IN_SVC;

   modport slave (
      input  IRQ, MASK_WE, MASK_IN, INTA_IN, DATA_RD, EOI,
      output INTA_OUT, INT, DATA, PENDING, IN_SVC
   );

   modport master (
      output IRQ, MASK_WE, MASK_IN, INTA_IN, DATA_RD, EOI,
      input  INTA_OUT, INT, DATA, PENDING, IN_SVC
   );

endinterface

// File: rtl/int_controller_prio_enc.sv
// Combinational rotated priority encoder: first set request bit found when
// searching upward from i_start and wrapping from N-1 back to 0.
module int_prio_enc
   import int_ctrl_pkg::*;
#(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_start,
   output logic          o_valid,
   output logic [IW-1:0] o_idx
);

   // Walk the order backwards so the earliest hit in rotated order is written last.
   always_comb begin
      int c;
      o_valid = 1'b0;
      o_idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         c = int'(i_start) + k;
         if (c >= N) c = c - N;
         if (i_req[c]) begin
            o_valid = 1'b1;
            o_idx   = IW'(c);
         end
      end
   end

endmodule

// File: rtl/int_controller.sv
// N-channel interrupt controller: latches requests, masks and prioritises them,
// raises INT, and returns the granted channel's vector after INTA_IN.
module int_controller
   import int_ctrl_pkg::*;
#(
   parameter int                N_CHAN     = 8,
   parameter logic [N_CHAN-1:0] EDGE_MASK  = {N_CHAN{1'b1}},
   parameter int                PRIO_MODE  = PRIO_FIXED,
   parameter logic [31:0]       VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0]       VEC_STRIDE = 32'h4
) (
   input  logic             CLK,
   input  logic             RST_N,
   int_controller_if.slave  bus
);

   localparam int IW = $clog2(N_CHAN);

   state_t            r_state;
   logic [N_CHAN-1:0] r_irq_q;
   logic [N_CHAN-1:0] r_pend;
   logic [N_CHAN-1:0] r_mask;
   logic [N_CHAN-1:0] r_insvc;
   logic [IW-1:0]     r_ptr;
   logic [31:0]       r_data;

   state_t            w_state_nxt;
   logic [N_CHAN-1:0] w_rise;
   logic [N_CHAN-1:0] w_higher;
   logic [N_CHAN-1:0] w_elig;
   logic [N_CHAN-1:0] w_grant_oh;
   logic [N_CHAN-1:0] w_eoi_oh;
   logic              w_win_vld;
   logic [IW-1:0]     w_win_idx;
   logic              w_svc_vld;
   logic [IW-1:0]     w_svc_idx;
   logic              w_grant;
   logic [IW-1:0]     w_ptr_nxt;

   assign w_rise = bus.IRQ & ~r_irq_q;

   int_prio_enc #(.N(N_CHAN), .IW(IW)) u_grant_enc (
      .i_req   (w_elig),
      .i_start (r_ptr),
      .o_valid (w_win_vld),
      .o_idx   (w_win_idx)
   );

   int_prio_enc #(.N(N_CHAN), .IW(IW)) u_svc_enc (
      .i_req   (r_insvc),
      .i_start (r_ptr),
      .o_valid (w_svc_vld),
      .o_idx   (w_svc_idx)
   );

   // Only channels ranked strictly above the top in-service channel may nest.
   always_comb begin
      w_higher = '1;
      if (w_svc_vld) begin
         for (int ch = 0; ch < N_CHAN; ch++) begin
            w_higher[ch] = rot_rank(ch, int'(r_ptr), N_CHAN) <
                           rot_rank(int'(w_svc_idx), int'(r_ptr), N_CHAN);
         end
      end
   end

   assign w_elig = r_pend & ~r_mask & w_higher;

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      case (r_state)
         IDLE: begin
            if (|w_elig) w_state_nxt = ASSERT;
         end
         ASSERT: begin
            if (!w_win_vld) begin
               w_state_nxt = IDLE;
            end else if (bus.INTA_IN) begin
               w_grant     = 1'b1;
               w_state_nxt = VECTOR;
            end
         end
         VECTOR: begin
            if (bus.DATA_RD) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_grant_oh = '0;
      w_eoi_oh   = '0;
      if (w_grant) w_grant_oh[w_win_idx] = 1'b1;
      if (bus.EOI && w_svc_vld) w_eoi_oh[w_svc_idx] = 1'b1;
   end

   assign w_ptr_nxt = (w_win_idx == IW'(N_CHAN - 1)) ? '0 : w_win_idx + IW'(1);

   // EOI retires from the old in-service set before the new grant bit lands.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_irq_q <= '0;
         r_pend  <= '0;
         r_mask  <= '1;
         r_insvc <= '0;
         r_ptr   <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_irq_q <= bus.IRQ;
         r_pend  <= (EDGE_MASK & ((r_pend & ~w_grant_oh) | w_rise)) |
                    (~EDGE_MASK & bus.IRQ);
         if (bus.MASK_WE) r_mask <= bus.MASK_IN;
         r_insvc <= (r_insvc & ~w_eoi_oh) | w_grant_oh;
         if (w_grant) begin
            r_data <= vec_addr(VEC_BASE, VEC_STRIDE, 32'(w_win_idx));
            if (PRIO_MODE == PRIO_ROTATE) r_ptr <= w_ptr_nxt;
         end
      end
   end

   assign bus.INT      = (r_state == ASSERT);
   assign bus.INTA_OUT = (r_state != ASSERT) & bus.INTA_IN;
   assign bus.DATA     = r_data;
   assign bus.PENDING  = r_pend;
   assign bus.IN_SVC   = r_insvc;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: a fixed-priority edge instance and a
// rotating-priority instance with channels 0/1 in level mode.
module tb_int_controller;

   logic CLK = 1'b0;
   logic RST_N;
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   int_controller_if #(.N_CHAN(8)) bf ();
   int_controller_if #(.N_CHAN(8)) br ();

   int_controller #(.N_CHAN(8), .PRIO_MODE(0)) u_fix (
      .CLK (CLK), .RST_N (RST_N), .bus (bf)
   );

   int_controller #(.N_CHAN(8), .EDGE_MASK(8'hFC), .PRIO_MODE(1)) u_rot (
      .CLK (CLK), .RST_N (RST_N), .bus (br)
   );

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic idle_inputs();
      bf.IRQ = '0; bf.MASK_WE = 0; bf.MASK_IN = '0; bf.INTA_IN = 0; bf.DATA_RD = 0; bf.EOI = 0;
      br.IRQ = '0; br.MASK_WE = 0; br.MASK_IN = '0; br.INTA_IN = 0; br.DATA_RD = 0; br.EOI = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      RST_N = 1'b0;
      cyc(2);
      RST_N = 1'b1;
      cyc(1);
   endtask

   task automatic unmask_all();
      bf.MASK_WE = 1; bf.MASK_IN = '0;
      br.MASK_WE = 1; br.MASK_IN = '0;
      cyc(1);
      bf.MASK_WE = 0; br.MASK_WE = 0;
   endtask

   task automatic pulse_irq(input logic [7:0] v);
      bf.IRQ = v;
      cyc(1);
      bf.IRQ = '0;
   endtask

   task automatic ack_fix();
      bf.INTA_IN = 1;
      cyc(1);
      bf.INTA_IN = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      RST_N = 1'b0;
      bf.INTA_IN = 1;
      #1;
      checks++; if (bf.INTA_OUT !== 1'b1) begin errors++; $display("FAIL rst_inta_out got %0b exp 1", bf.INTA_OUT); end
      checks++; if (bf.INT !== 1'b0) begin errors++; $display("FAIL rst_int got %0b exp 0", bf.INT); end
      checks++; if (bf.DATA !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", bf.DATA); end
      checks++; if (bf.PENDING !== 8'h00) begin errors++; $display("FAIL rst_pending got %h exp 00", bf.PENDING); end
      checks++; if (bf.IN_SVC !== 8'h00) begin errors++; $display("FAIL rst_in_svc got %h exp 00", bf.IN_SVC); end
      bf.INTA_IN = 0;
      cyc(2);
      RST_N = 1'b1;
      cyc(1);
      pulse_irq(8'h08);
      checks++; if (bf.PENDING !== 8'h08) begin errors++; $display("FAIL rst_masked_pending got %h exp 08", bf.PENDING); end
      cyc(1);
      checks++; if (bf.INT !== 1'b0) begin errors++; $display("FAIL rst_mask_default_int got %0b exp 0", bf.INT); end
   endtask

   task automatic test_single();
      do_reset();
      unmask_all();
      pulse_irq(8'h08);
      checks++; if (bf.PENDING !== 8'h08) begin errors++; $display("FAIL t1_pending got %h exp 08", bf.PENDING); end
      checks++; if (bf.INT !== 1'b0) begin errors++; $display("FAIL t1_int_early got %0b exp 0", bf.INT); end
      cyc(1);
      checks++; if (bf.INT !== 1'b1) begin errors++; $display("FAIL t1_int got %0b exp 1", bf.INT); end
      ack_fix();
      checks++; if (bf.DATA !== 32'h10C) begin errors++; $display("FAIL t1_data got %h exp 0000010c", bf.DATA); end
      checks++; if (bf.IN_SVC !== 8'h08) begin errors++; $display("FAIL t1_in_svc got %h exp 08", bf.IN_SVC); end
      checks++; if (bf.PENDING !== 8'h00) begin errors++; $display("FAIL t1_pend_clr got %h exp 00", bf.PENDING); end
      checks++; if (bf.INT !== 1'b0) begin errors++; $display("FAIL t1_int_vector got %0b exp 0", bf.INT); end
      bf.DATA_RD = 1;
      cyc(1);
      bf.DATA_RD = 0;
      cyc(1);
      checks++; if (bf.DATA !== 32'h10C) begin errors++; $display("FAIL t1_data_hold got %h exp 0000010c", bf.DATA); end
   endtask

   task automatic test_fixed_prio();
      do_reset();
      unmask_all();
      pulse_irq(8'h24);
      cyc(1);
      checks++; if (bf.INT !== 1'b1) begin errors++; $display("FAIL t2_int got %0b exp 1", bf.INT); end
      ack_fix();
      checks++; if (bf.DATA !== 32'h108) begin errors++; $display("FAIL t2_data_ch2 got %h exp 00000108", bf.DATA); end
      checks++; if (bf.PENDING !== 8'h20) begin errors++; $display("FAIL t2_pending got %h exp 20", bf.PENDING); end
      bf.DATA_RD = 1; bf.EOI = 1;
      cyc(1);
      bf.DATA_RD = 0; bf.EOI = 0;
      checks++; if (bf.IN_SVC !== 8'h00) begin errors++; $display("FAIL t2_eoi got %h exp 00", bf.IN_SVC); end
      cyc(1);
      checks++; if (bf.INT !== 1'b1) begin errors++; $display("FAIL t2_int2 got %0b exp 1", bf.INT); end
      ack_fix();
      checks++; if (bf.DATA !== 32'h114) begin errors++; $display("FAIL t2_data_ch5 got %h exp 00000114", bf.DATA); end
      checks++; if (bf.IN_SVC !== 8'h20) begin errors++; $display("FAIL t2_in_svc got %h exp 20", bf.IN_SVC); end
   endtask

   task automatic test_nesting();
      do_reset();
      unmask_all();
      pulse_irq(8'h10);
      cyc(1);
      ack_fix();
      checks++; if (bf.DATA !== 32'h110) begin errors++; $display("FAIL t3_data_ch4 got %h exp 00000110", bf.DATA); end
      bf.DATA_RD = 1;
      cyc(1);
      bf.DATA_RD = 0;
      pulse_irq(8'h40);
      cyc(1);
      checks++; if (bf.PENDING !== 8'h40) begin errors++; $display("FAIL t3_pend_ch6 got %h exp 40", bf.PENDING); end
      checks++; if (bf.INT !== 1'b0) begin errors++; $display("FAIL t3_int_blocked got %0b exp 0", bf.INT); end
      pulse_irq(8'h02);
      cyc(1);
      checks++; if (bf.INT !== 1'b1) begin errors++; $display("FAIL t3_int_nest got %0b exp 1", bf.INT); end
      ack_fix();
      checks++; if (bf.IN_SVC !== 8'h12) begin errors++; $display("FAIL t3_in_svc got %h exp 12", bf.IN_SVC); end
      checks++; if (bf.DATA !== 32'h104) begin errors++; $display("FAIL t3_data_ch1 got %h exp 00000104", bf.DATA); end
   endtask

   task automatic test_rotate();
      logic [31:0] exp_data [3];
      logic [7:0]  exp_svc  [3];
      exp_data[0] = 32'h100; exp_data[1] = 32'h104; exp_data[2] = 32'h100;
      exp_svc[0]  = 8'h01;   exp_svc[1]  = 8'h02;   exp_svc[2]  = 8'h01;
      do_reset();
      unmask_all();
      br.IRQ = 8'h03;
      cyc(2);
      for (int i = 0; i < 3; i++) begin
         checks++; if (br.INT !== 1'b1) begin errors++; $display("FAIL t4_int[%0d] got %0b exp 1", i, br.INT); end
         br.INTA_IN = 1;
         cyc(1);
         br.INTA_IN = 0;
         checks++; if (br.DATA !== exp_data[i]) begin errors++; $display("FAIL t4_data[%0d] got %h exp %h", i, br.DATA, exp_data[i]); end
         checks++; if (br.IN_SVC !== exp_svc[i]) begin errors++; $display("FAIL t4_in_svc[%0d] got %h exp %h", i, br.IN_SVC, exp_svc[i]); end
         br.DATA_RD = 1; br.EOI = 1;
         cyc(1);
         br.DATA_RD = 0; br.EOI = 0;
         cyc(1);
      end
      br.IRQ = '0;
      cyc(2);
   endtask

   task automatic test_chain_mask();
      do_reset();
      unmask_all();
      bf.INTA_IN = 1;
      #1;
      checks++; if (bf.INTA_OUT !== 1'b1) begin errors++; $display("FAIL t5_pass_hi got %0b exp 1", bf.INTA_OUT); end
      bf.INTA_IN = 0;
      #1;
      checks++; if (bf.INTA_OUT !== 1'b0) begin errors++; $display("FAIL t5_pass_lo got %0b exp 0", bf.INTA_OUT); end
      cyc(1);
      pulse_irq(8'h08);
      cyc(1);
      checks++; if (bf.INT !== 1'b1) begin errors++; $display("FAIL t5_int got %0b exp 1", bf.INT); end
      bf.INTA_IN = 1;
      #1;
      checks++; if (bf.INTA_OUT !== 1'b0) begin errors++; $display("FAIL t5_consume got %0b exp 0", bf.INTA_OUT); end
      bf.INTA_IN = 0;
      bf.MASK_WE = 1; bf.MASK_IN = 8'h08;
      cyc(1);
      bf.MASK_WE = 0; bf.MASK_IN = '0;
      checks++; if (bf.INT !== 1'b1) begin errors++; $display("FAIL t5_int_mask_lat got %0b exp 1", bf.INT); end
      cyc(1);
      checks++; if (bf.INT !== 1'b0) begin errors++; $display("FAIL t5_withdraw got %0b exp 0", bf.INT); end
      checks++; if (bf.PENDING !== 8'h08) begin errors++; $display("FAIL t5_pending got %h exp 08", bf.PENDING); end
      checks++; if (bf.IN_SVC !== 8'h00) begin errors++; $display("FAIL t5_in_svc got %h exp 00", bf.IN_SVC); end
      bf.INTA_IN = 1;
      #1;
      checks++; if (bf.INTA_OUT !== 1'b1) begin errors++; $display("FAIL t5_pass_idle got %0b exp 1", bf.INTA_OUT); end
      bf.INTA_IN = 0;
      cyc(1);
   endtask

   task automatic test_reset_mid();
      do_reset();
      unmask_all();
      pulse_irq(8'h20);
      cyc(1);
      ack_fix();
      checks++; if (bf.DATA !== 32'h114) begin errors++; $display("FAIL t6_data got %h exp 00000114", bf.DATA); end
      pulse_irq(8'h01);
      #2;
      RST_N = 1'b0;
      #1;
      checks++; if (bf.INT !== 1'b0) begin errors++; $display("FAIL t6_int got %0b exp 0", bf.INT); end
      checks++; if (bf.DATA !== 32'h0) begin errors++; $display("FAIL t6_data_rst got %h exp 0", bf.DATA); end
      checks++; if (bf.PENDING !== 8'h00) begin errors++; $display("FAIL t6_pending got %h exp 00", bf.PENDING); end
      checks++; if (bf.IN_SVC !== 8'h00) begin errors++; $display("FAIL t6_in_svc got %h exp 00", bf.IN_SVC); end
      cyc(1);
      RST_N = 1'b1;
      cyc(1);
      unmask_all();
      cyc(2);
      checks++; if (bf.INT !== 1'b0) begin errors++; $display("FAIL t6_no_int got %0b exp 0", bf.INT); end
      checks++; if (bf.PENDING !== 8'h00) begin errors++; $display("FAIL t6_pend_after got %h exp 00", bf.PENDING); end
   endtask

   initial begin
      RST_N = 1'b0;
      idle_inputs();
      @(negedge CLK);
      test_reset();
      test_single();
      test_fixed_prio();
      test_nesting();
      test_rotate();
      test_chain_mask();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
